// File: rtl/cr_xp10_decomp_fe_bit_aligner.sv
// XP10 decompressor front-end bit aligner: FIFO-buffered beats with a
// segment-latched leading bit offset stripped across beat boundaries.
module cr_xp10_decomp_fe_bit_aligner #(
   parameter int DWIDTH       = 64,
   parameter int DEPTH        = 8,
   parameter int AFULL_MARGIN = 2,
   localparam int BVW         = $clog2(DWIDTH / 8),
   localparam int OW          = $clog2(DWIDTH)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_wr,
   input  logic [DWIDTH-1:0] in_data,
   input  logic [BVW-1:0]    in_bytes_valid,
   input  logic              in_sof,
   input  logic              in_eob,
   input  logic              in_eof,
   output logic              in_afull,
   input  logic [OW-1:0]     align_offset,
   input  logic              align_clear,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DWIDTH-1:0] out_data,
   output logic [BVW-1:0]    out_bytes_valid,
   output logic              out_sof,
   output logic              out_eob,
   output logic              out_eof,
   output logic              out_empty
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);
   localparam int LW = OW + 1;

   typedef struct packed {
      logic [DWIDTH-1:0] data;
      logic [BVW-1:0]    bv;
      logic              sof;
      logic              eob;
      logic              eof;
   } beat_t;

   typedef enum logic [1:0] {IDLE, HOLD, FLUSH} state_t;

   beat_t             mem [DEPTH];
   logic [AW-1:0]     wr_ptr;
   logic [AW-1:0]     rd_ptr;
   logic [CW-1:0]     used;
   logic              wr_ok;
   logic              pop;
   logic              out_free;

   state_t            state;
   state_t            state_nx;
   beat_t             head;
   beat_t             hold;
   beat_t             hold_nx;
   logic [OW-1:0]     off;
   logic [OW-1:0]     off_nx;
   logic [LW-1:0]     c_bits;
   logic [LW-1:0]     h_bits;
   logic [LW-1:0]     vb;
   logic              c_last;
   logic              emit;
   logic [DWIDTH-1:0] e_data;
   logic              e_sof;
   logic              e_eob;
   logic              e_eof;
   logic              e_empty;

   function automatic logic [LW-1:0] bits_of(input logic [BVW-1:0] bv);
      return (bv == '0) ? LW'(DWIDTH) : LW'({bv, 3'b000});
   endfunction

   function automatic logic [BVW-1:0] bv_of(input logic [LW-1:0] n);
      return BVW'(({1'b0, n} + (LW + 1)'(7)) >> 3);
   endfunction

   function automatic logic [DWIDTH-1:0] mask_of(input logic [LW-1:0] n);
      logic [DWIDTH-1:0] one;
      one = {{(DWIDTH - 1){1'b0}}, 1'b1};
      return (n >= LW'(DWIDTH)) ? '1 : (one << n) - one;
   endfunction

   function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
      return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign head     = mem[rd_ptr];
   assign out_free = !out_valid || out_ready;
   assign wr_ok    = in_wr && !align_clear && (used != CW'(DEPTH));
   assign pop      = (used != '0) && out_free && (state != FLUSH) && !align_clear;
   assign in_afull = used >= CW'(DEPTH - AFULL_MARGIN);

   always_ff @(posedge clk) begin
      if (wr_ok) begin
         mem[wr_ptr] <= '{data: in_data, bv: in_bytes_valid,
                          sof: in_sof, eob: in_eob, eof: in_eof};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         used   <= '0;
      end else if (align_clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         used   <= '0;
      end else begin
         if (wr_ok) wr_ptr <= nxt(wr_ptr);
         if (pop)   rd_ptr <= nxt(rd_ptr);
         used <= used + CW'(wr_ok) - CW'(pop);
      end
   end

   always_comb begin
      state_nx = state;
      hold_nx  = hold;
      off_nx   = off;
      emit     = 1'b0;
      vb       = '0;
      e_data   = '0;
      e_sof    = 1'b0;
      e_eob    = 1'b0;
      e_eof    = 1'b0;
      e_empty  = 1'b0;
      c_last   = head.eob || head.eof;
      c_bits   = bits_of(head.bv);
      h_bits   = bits_of(hold.bv);
      unique case (state)
         IDLE: if (pop) begin
            if (!c_last) begin
               state_nx = HOLD;
               off_nx   = align_offset;
               hold_nx  = head;
            end else begin
               emit  = 1'b1;
               e_sof = head.sof;
               e_eob = head.eob;
               e_eof = head.eof;
               if (c_bits > LW'(align_offset)) begin
                  vb     = c_bits - LW'(align_offset);
                  e_data = head.data >> align_offset;
               end else begin
                  e_empty = 1'b1;
               end
            end
         end
         HOLD: if (pop) begin
            emit    = 1'b1;
            e_sof   = hold.sof;
            e_data  = DWIDTH'({head.data, hold.data} >> off);
            hold_nx = head;
            // sof only ever travels with the segment's first held beat
            hold_nx.sof = 1'b0;
            if (!c_last) begin
               vb = LW'(DWIDTH);
            end else if (c_bits <= LW'(off)) begin
               vb       = LW'(DWIDTH) - LW'(off) + c_bits;
               e_eob    = head.eob;
               e_eof    = head.eof;
               state_nx = IDLE;
            end else begin
               vb       = LW'(DWIDTH);
               state_nx = FLUSH;
            end
         end
         FLUSH: if (out_free && !align_clear) begin
            emit     = 1'b1;
            vb       = h_bits - LW'(off);
            e_data   = hold.data >> off;
            e_eob    = hold.eob;
            e_eof    = hold.eof;
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
      e_data = e_data & mask_of(vb);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state           <= IDLE;
         hold            <= '0;
         off             <= '0;
         out_valid       <= 1'b0;
         out_data        <= '0;
         out_bytes_valid <= '0;
         out_sof         <= 1'b0;
         out_eob         <= 1'b0;
         out_eof         <= 1'b0;
         out_empty       <= 1'b0;
      end else if (align_clear) begin
         state     <= IDLE;
         hold      <= '0;
         out_valid <= 1'b0;
      end else begin
         state <= state_nx;
         hold  <= hold_nx;
         off   <= off_nx;
         if (emit) begin
            out_valid       <= 1'b1;
            out_data        <= e_data;
            out_bytes_valid <= bv_of(vb);
            out_sof         <= e_sof;
            out_eob         <= e_eob;
            out_eof         <= e_eof;
            out_empty       <= e_empty;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_cr_xp10_decomp_fe_bit_aligner.sv
// Bench for cr_xp10_decomp_fe_bit_aligner: segments are flattened to a bit
// queue, the offset dropped, and the rest chunked into expected beats.
module tb_cr_xp10_decomp_fe_bit_aligner;
   localparam int DW  = 64;
   localparam int BVW = 3;
   localparam int OW  = 6;

   logic          clk             = 1'b0;
   logic          rst_n           = 1'b0;
   logic          in_wr           = 1'b0;
   logic [DW-1:0] in_data         = '0;
   logic [BVW-1:0] in_bytes_valid = '0;
   logic          in_sof          = 1'b0;
   logic          in_eob          = 1'b0;
   logic          in_eof          = 1'b0;
   logic          in_afull;
   logic [OW-1:0] align_offset    = '0;
   logic          align_clear     = 1'b0;
   logic          out_valid;
   logic          out_ready       = 1'b0;
   logic [DW-1:0] out_data;
   logic [BVW-1:0] out_bytes_valid;
   logic          out_sof;
   logic          out_eob;
   logic          out_eof;
   logic          out_empty;

   cr_xp10_decomp_fe_bit_aligner #(
      .DWIDTH(DW), .DEPTH(8), .AFULL_MARGIN(2)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .in_wr(in_wr), .in_data(in_data), .in_bytes_valid(in_bytes_valid),
      .in_sof(in_sof), .in_eob(in_eob), .in_eof(in_eof),
      .in_afull(in_afull),
      .align_offset(align_offset), .align_clear(align_clear),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_bytes_valid(out_bytes_valid),
      .out_sof(out_sof), .out_eob(out_eob), .out_eof(out_eof),
      .out_empty(out_empty)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [DW-1:0]  data;
      logic [BVW-1:0] bv;
      logic           sof;
      logic           eob;
      logic           eof;
      logic           empty;
   } exp_t;

   exp_t           exp_q[$];
   int             n_chk  = 0;
   int             n_fail = 0;
   int             cur_off = 0;
   bit             rnd_ready = 1'b0;
   bit             ready_force = 1'b0;
   logic [DW-1:0]  seg_d [16];
   logic [BVW-1:0] seg_bv [16];
   logic           seg_sof, seg_eob, seg_eof;

   task automatic check(input string tag, input logic [127:0] got,
                        input logic [127:0] want);
      n_chk++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got %h want %h", tag, got, want);
      end
   endtask

   task automatic model_seg(input int n);
      bit   q[$];
      exp_t e;
      int   nb;
      bit   first;
      for (int i = 0; i < n; i++) begin
         nb = (seg_bv[i] == 0) ? DW : int'(seg_bv[i]) * 8;
         for (int b = 0; b < nb; b++) q.push_back(seg_d[i][b]);
      end
      if (q.size() <= cur_off) begin
         e.data = '0; e.bv = '0; e.empty = 1'b1;
         e.sof = seg_sof; e.eob = seg_eob; e.eof = seg_eof;
         exp_q.push_back(e);
         return;
      end
      for (int i = 0; i < cur_off; i++) void'(q.pop_front());
      first = 1'b1;
      while (q.size() > 0) begin
         nb = (q.size() > DW) ? DW : q.size();
         e.data = '0;
         for (int b = 0; b < nb; b++) e.data[b] = q.pop_front();
         e.bv    = BVW'(((nb + 7) / 8) % (DW / 8));
         e.empty = 1'b0;
         e.sof   = first && seg_sof;
         e.eob   = (q.size() == 0) && seg_eob;
         e.eof   = (q.size() == 0) && seg_eof;
         first   = 1'b0;
         exp_q.push_back(e);
      end
   endtask

   task automatic gen_seg(input int n);
      int r;
      for (int i = 0; i < n; i++) begin
         seg_d[i]  = {$urandom, $urandom};
         seg_bv[i] = (i == n - 1) ? BVW'($urandom_range(0, 7)) : '0;
      end
      seg_sof = 1'($urandom_range(0, 1));
      r = $urandom_range(1, 3);
      seg_eob = r[0];
      seg_eof = r[1];
   endtask

   task automatic wr_beat(input logic [DW-1:0] d, input logic [BVW-1:0] bv,
                          input logic s, input logic eb, input logic ef);
      int t = 0;
      while (in_afull && t < 2000) begin
         @(posedge clk); #1;
         t++;
      end
      if (t >= 2000) check("afull_wait", 128'(1), 128'(0));
      in_wr = 1'b1; in_data = d; in_bytes_valid = bv;
      in_sof = s; in_eob = eb; in_eof = ef;
      @(posedge clk); #1;
      in_wr = 1'b0; in_sof = 1'b0; in_eob = 1'b0; in_eof = 1'b0;
   endtask

   task automatic send_seg(input int n, input bit push);
      if (push) model_seg(n);
      for (int i = 0; i < n; i++) begin
         wr_beat(seg_d[i], seg_bv[i], (i == 0) && seg_sof,
                 (i == n - 1) && seg_eob, (i == n - 1) && seg_eof);
      end
   endtask

   task automatic set_off(input int o);
      cur_off = o;
      align_offset = OW'(o);
   endtask

   task automatic drain();
      int t = 0;
      while (exp_q.size() != 0 && t < 5000) begin
         @(posedge clk); #1;
         t++;
      end
      check("drain", 128'(exp_q.size()), 128'(0));
      exp_q.delete();
      @(posedge clk); #1;
      check("idle_valid", 128'(out_valid), 128'(0));
   endtask

   always @(posedge clk) begin
      #2;
      out_ready = rnd_ready ? ($urandom_range(0, 3) != 0) : ready_force;
   end

   logic [71:0] prev_vec;
   bit          prev_hold = 1'b0;
   exp_t        me;
   always @(negedge clk) begin
      if (rst_n) begin
         if (prev_hold) begin
            check("stable", 128'({out_valid, out_sof, out_eob, out_eof,
                  out_empty, out_bytes_valid, out_data}), 128'(prev_vec));
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               check("extra_beat", 128'(out_data), 128'(0));
            end else begin
               me = exp_q.pop_front();
               check("beat_data", 128'(out_data), 128'(me.data));
               check("beat_bv", 128'(out_bytes_valid), 128'(me.bv));
               check("beat_flags", 128'({out_sof, out_eob, out_eof, out_empty}),
                     128'({me.sof, me.eob, me.eof, me.empty}));
            end
         end
         prev_hold = out_valid && !out_ready && !align_clear;
         prev_vec  = {out_valid, out_sof, out_eob, out_eof, out_empty,
                      out_bytes_valid, out_data};
      end else begin
         prev_hold = 1'b0;
      end
   end

   initial begin
      #500000;
      $display("FAIL timeout: got running want finished");
      $fatal(1);
   end

   initial begin
      repeat (3) @(posedge clk);
      #1;
      check("rst_valid", 128'(out_valid), 128'(0));
      check("rst_data", 128'(out_data), 128'(0));
      check("rst_bv", 128'(out_bytes_valid), 128'(0));
      check("rst_flags", 128'({out_sof, out_eob, out_eof, out_empty}), 128'(0));
      check("rst_afull", 128'(in_afull), 128'(0));
      rst_n = 1'b1;
      ready_force = 1'b1;
      @(posedge clk); #1;

      set_off(0);
      gen_seg(3);
      seg_bv[2] = '0; seg_sof = 1'b1; seg_eob = 1'b0; seg_eof = 1'b1;
      send_seg(3, 1'b1);
      drain();

      set_off(8);
      gen_seg(2);
      seg_bv[1] = '0; seg_eob = 1'b0; seg_eof = 1'b1;
      send_seg(2, 1'b1);
      drain();

      set_off(12);
      gen_seg(2);
      seg_bv[1] = 3'd2; seg_eob = 1'b1; seg_eof = 1'b0;
      send_seg(2, 1'b1);
      drain();

      set_off(16);
      gen_seg(1);
      seg_bv[0] = 3'd1; seg_sof = 1'b1; seg_eob = 1'b0; seg_eof = 1'b1;
      model_seg(1);
      in_wr = 1'b1; in_data = seg_d[0]; in_bytes_valid = seg_bv[0];
      in_sof = 1'b1; in_eof = 1'b1;
      @(posedge clk); #1;
      in_wr = 1'b0; in_sof = 1'b0; in_eof = 1'b0;
      check("lat_cycle1", 128'(out_valid), 128'(0));
      @(posedge clk); #1;
      check("lat_cycle2", 128'(out_valid), 128'(1));
      check("empty_beat", 128'({out_empty, out_eof, out_data}),
            128'({1'b1, 1'b1, 64'h0}));
      drain();

      ready_force = 1'b0;
      @(posedge clk); #1;
      set_off(0);
      gen_seg(8);
      seg_bv[7] = '0; seg_sof = 1'b1; seg_eob = 1'b0; seg_eof = 1'b1;
      model_seg(8);
      for (int k = 0; k < 8; k++) begin
         in_wr = 1'b1; in_data = seg_d[k]; in_bytes_valid = '0;
         in_sof = (k == 0); in_eof = (k == 7);
         @(posedge clk); #1;
         check($sformatf("afull_w%0d", k), 128'(in_afull), 128'(k == 7));
      end
      in_wr = 1'b0; in_sof = 1'b0; in_eof = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("afull_hold", 128'(in_afull), 128'(1));
      ready_force = 1'b1;
      drain();
      check("afull_low", 128'(in_afull), 128'(0));

      ready_force = 1'b0;
      @(posedge clk); #1;
      set_off(4);
      gen_seg(3);
      seg_bv[2] = '0; seg_eob = 1'b0; seg_eof = 1'b1;
      send_seg(3, 1'b0);
      check("pre_clr_valid", 128'(out_valid), 128'(1));
      align_clear = 1'b1;
      in_wr = 1'b1; in_data = {$urandom, $urandom}; in_eof = 1'b1;
      @(posedge clk); #1;
      align_clear = 1'b0; in_wr = 1'b0; in_eof = 1'b0;
      check("clr_valid", 128'(out_valid), 128'(0));
      repeat (3) @(posedge clk);
      #1;
      check("clr_quiet", 128'(out_valid), 128'(0));
      ready_force = 1'b1;
      set_off(20);
      gen_seg(2);
      send_seg(2, 1'b1);
      drain();

      rnd_ready = 1'b1;
      for (int p = 0; p < 25; p++) begin
         set_off($urandom_range(0, 63));
         for (int s = 0; s < $urandom_range(1, 4); s++) begin
            int n;
            n = $urandom_range(1, 4);
            gen_seg(n);
            send_seg(n, 1'b1);
            repeat ($urandom_range(0, 2)) begin
               @(posedge clk); #1;
            end
         end
         drain();
      end
      rnd_ready = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
